ks_sum_stage: RTL and testbench

Registered sum stage of the 16-bit pipelined Kogge-Stone adder, directly downstream of the final prefix stage. It consumes the carry-in, the saved propagate bits, the final group-generate (carry) vector and the all-bits group propagate. It forms the sum, carry-out and signed overflow, and presents them through a valid/ready output register with a one-entry skid buffer. It also keeps sticky and counted overflow status for the FFT datapath's scaling control.

---
 rtl/ks_pkg.sv | 20 ++
 rtl/ks_sum_core.sv | 42 ++++
 rtl/ks_sum_stage.sv | 119 +++++++++++
 tb/tb_ks_sum_stage.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ks_pkg.sv
// Shared constants, result record and saturating-increment helper for the Kogge-Stone sum stage.
package ks_pkg;

  localparam int unsigned KS_WIDTH     = 16;
  localparam logic [15:0] KS_SAT_POS   = 16'h7FFF;
  localparam logic [15:0] KS_SAT_NEG   = 16'h8000;
  localparam int unsigned KS_OVF_CNT_W = 8;

  typedef struct packed {
    logic [KS_WIDTH-1:0] sum;
    logic                cout;
    logic                ovf;
    logic                p_all;
  } ks_res_t;

  function automatic logic [KS_OVF_CNT_W-1:0] sat_inc(input logic [KS_OVF_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ks_sum_core.sv
// Combinational sum/carry-out/overflow from the final prefix-stage outputs.
// With KS_SUM_SAT_EN defined, overflowed sums clamp to the signed extreme.
module ks_sum_core
  import ks_pkg::*;
(
  input  logic                c0_i,
  input  logic [KS_WIDTH-1:0] p_save_i,
  input  logic [KS_WIDTH-1:0] gk_i,
  output logic [KS_WIDTH-1:0] sum_o,
  output logic                cout_o,
  output logic                ovf_o
);

  logic [KS_WIDTH-1:0] carry;
  logic [KS_WIDTH-1:0] raw;

  // gk_i[k] is the carry into bit k+1, so the carry vector is gk shifted up by one.
  assign carry  = {gk_i[KS_WIDTH-2:0], c0_i};
  assign raw    = p_save_i ^ carry;
  assign cout_o = gk_i[KS_WIDTH-1];
  assign ovf_o  = gk_i[KS_WIDTH-2] ^ gk_i[KS_WIDTH-1];

`ifdef KS_SUM_SAT_EN
  logic pos_ovf;
  logic neg_ovf;

  assign pos_ovf = gk_i[KS_WIDTH-2] & ~gk_i[KS_WIDTH-1];
  assign neg_ovf = ~gk_i[KS_WIDTH-2] & gk_i[KS_WIDTH-1];

  always_comb begin
    sum_o = raw;
    if (pos_ovf) begin
      sum_o = KS_SAT_POS;
    end else if (neg_ovf) begin
      sum_o = KS_SAT_NEG;
    end
  end
`else
  assign sum_o = raw;
`endif

endmodule

// File: rtl/ks_sum_stage.sv
// Registered Kogge-Stone sum stage: output register plus one-entry skid buffer, with sticky and
// counted overflow status. Saturating sums are selected by KS_SUM_SAT_EN (see ks_sum_core).
module ks_sum_stage
  import ks_pkg::*;
#(
  parameter int unsigned WIDTH = KS_WIDTH
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic                    i_c0,
  input  logic [WIDTH-1:0]        i_p_save,
  input  logic [WIDTH-1:0]        i_gk,
  input  logic                    i_p_addn,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [WIDTH-1:0]        o_sum,
  output logic                    o_cout,
  output logic                    o_ovf,
  output logic                    o_p_all,
  input  logic                    i_ovf_clr,
  output logic                    o_ovf_sticky,
  output logic [KS_OVF_CNT_W-1:0] o_ovf_cnt
);

  ks_res_t res;
  ks_res_t out_q, out_d;
  ks_res_t skd_q, skd_d;
  logic    out_valid_q, out_valid_d;
  logic    skd_valid_q, skd_valid_d;
  logic    ready_q, ready_d;
  logic    sticky_q, sticky_d;
  logic [KS_OVF_CNT_W-1:0] cnt_q, cnt_d, cnt_base;

  logic in_acc;
  logic out_acc;
  logic out_free;

  ks_sum_core u_core (
    .c0_i     (i_c0),
    .p_save_i (i_p_save),
    .gk_i     (i_gk),
    .sum_o    (res.sum),
    .cout_o   (res.cout),
    .ovf_o    (res.ovf)
  );

  assign res.p_all = i_p_addn;

  assign in_acc   = i_valid & ready_q;
  assign out_acc  = out_valid_q & i_ready;
  assign out_free = ~out_valid_q | out_acc;

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    skd_d       = skd_q;
    skd_valid_d = skd_valid_q;
    if (out_free) begin
      // ready_q is low whenever SKD is full, so SKD draining and in_acc never coincide.
      if (skd_valid_q) begin
        out_d       = skd_q;
        out_valid_d = 1'b1;
        skd_valid_d = 1'b0;
      end else if (in_acc) begin
        out_d       = res;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_acc) begin
      skd_d       = res;
      skd_valid_d = 1'b1;
    end
    ready_d = ~skd_valid_d;
  end

  // Clear and an overflowed accept in the same cycle leave sticky=1, count=1.
  always_comb begin
    cnt_base = i_ovf_clr ? '0 : cnt_q;
    sticky_d = sticky_q & ~i_ovf_clr;
    cnt_d    = cnt_base;
    if (in_acc && res.ovf) begin
      sticky_d = 1'b1;
      cnt_d    = sat_inc(cnt_base);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_q       <= '0;
      skd_q       <= '0;
      out_valid_q <= 1'b0;
      skd_valid_q <= 1'b0;
      ready_q     <= 1'b1;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_q       <= out_d;
      skd_q       <= skd_d;
      out_valid_q <= out_valid_d;
      skd_valid_q <= skd_valid_d;
      ready_q     <= ready_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
    end
  end

  assign o_ready      = ready_q;
  assign o_valid      = out_valid_q;
  assign o_sum        = out_q.sum;
  assign o_cout       = out_q.cout;
  assign o_ovf        = out_q.ovf;
  assign o_p_all      = out_q.p_all;
  assign o_ovf_sticky = sticky_q;
  assign o_ovf_cnt    = cnt_q;

endmodule

// File: tb/tb_ks_sum_stage.sv
// Scoreboard bench for ks_sum_stage: operands are turned into prefix-tree outputs, expected
// results come from plain 17-bit arithmetic, and a negedge monitor pops and compares.
module tb_ks_sum_stage;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic        i_c0;
  logic [15:0] i_p_save;
  logic [15:0] i_gk;
  logic        i_p_addn;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_sum;
  logic        o_cout;
  logic        o_ovf;
  logic        o_p_all;
  logic        i_ovf_clr;
  logic        o_ovf_sticky;
  logic [7:0]  o_ovf_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] cur_a, cur_b;
  logic        cur_c0;
  bit          rand_mode = 1'b0;

  logic [18:0] q[$];
  int          m_cnt;
  bit          m_sticky;

`ifdef KS_SUM_SAT_EN
  localparam logic [15:0] EXP_POS = 16'h7FFF;
  localparam logic [15:0] EXP_NEG = 16'h8000;
`else
  localparam logic [15:0] EXP_POS = 16'h8000;
  localparam logic [15:0] EXP_NEG = 16'h0000;
`endif

  ks_sum_stage #(.WIDTH(16)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_c0         (i_c0),
    .i_p_save     (i_p_save),
    .i_gk         (i_gk),
    .i_p_addn     (i_p_addn),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_sum        (o_sum),
    .o_cout       (o_cout),
    .o_ovf        (o_ovf),
    .o_p_all      (o_p_all),
    .i_ovf_clr    (i_ovf_clr),
    .o_ovf_sticky (o_ovf_sticky),
    .o_ovf_cnt    (o_ovf_cnt)
  );

  always #5 i_clk = ~i_clk;

  // Carry into bit k+1 = bit k+1 of the sum of the low k+1 operand bits plus carry-in.
  function automatic logic [15:0] gk_of(input logic [15:0] a, input logic [15:0] b,
                                        input logic c0);
    logic [15:0] g;
    logic [15:0] m;
    logic [16:0] part;
    for (int k = 0; k < 16; k++) begin
      m    = 16'hFFFF >> (15 - k);
      part = {1'b0, a & m} + {1'b0, b & m} + {16'b0, c0};
      g[k] = part[k+1];
    end
    return g;
  endfunction

  // Expected {sum, cout, ovf, p_all} from two's-complement arithmetic.
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic c0);
    logic [16:0] full;
    logic [15:0] s;
    logic        ov;
    full = {1'b0, a} + {1'b0, b} + {16'b0, c0};
    ov   = (a[15] == b[15]) && (full[15] != a[15]);
    s    = full[15:0];
`ifdef KS_SUM_SAT_EN
    if (ov) s = a[15] ? 16'h8000 : 16'h7FFF;
`endif
    return {s, full[16], ov, &(a ^ b)};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
    if (rand_mode) begin
      i_ready   = ($urandom_range(0, 3) != 0);
      i_ovf_clr = ($urandom_range(0, 31) == 0);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic c0);
    cur_a    = a;
    cur_b    = b;
    cur_c0   = c0;
    i_c0     = c0;
    i_p_save = a ^ b;
    i_gk     = gk_of(a, b, c0);
    i_p_addn = &(a ^ b);
    i_valid  = 1'b1;
  endtask

  task automatic wait_accept();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge i_clk);
      done = o_ready;
      step();
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got o_ready=0 for 200 cycles expected acceptance");
    end
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c0);
    drive(a, b, c0);
    wait_accept();
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) step();
  endtask

  // Monitor/scoreboard: compare on output accept, push on input accept, track status.
  initial begin
    logic [18:0] e;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        q.delete();
        m_cnt    = 0;
        m_sticky = 1'b0;
      end else begin
        check("ovf_cnt", {24'b0, o_ovf_cnt}, m_cnt);
        check("ovf_sticky", {31'b0, o_ovf_sticky}, {31'b0, m_sticky});
        if (o_valid && i_ready) begin
          if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_out: got sum=%0h with empty queue expected no output",
                     o_sum);
          end else begin
            e = q.pop_front();
            check("out_data", {13'b0, o_sum, o_cout, o_ovf, o_p_all}, {13'b0, e});
          end
        end
        if (i_ovf_clr) begin
          m_cnt    = 0;
          m_sticky = 1'b0;
        end
        if (i_valid && o_ready) begin
          e = model(cur_a, cur_b, cur_c0);
          q.push_back(e);
          if (e[1]) begin
            m_sticky = 1'b1;
            if (m_cnt != 255) m_cnt++;
          end
        end
      end
    end
  end

  initial begin
    i_rst_n   = 1'b0;
    i_valid   = 1'b0;
    i_ready   = 1'b1;
    i_ovf_clr = 1'b0;
    drive(16'h0, 16'h0, 1'b0);
    i_valid = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_valid", {31'b0, o_valid}, 0);
    check("rst_ready", {31'b0, o_ready}, 1);
    check("rst_sum", {16'b0, o_sum}, 0);
    i_rst_n = 1'b1;
    step();

    send(16'h1234, 16'h1111, 1'b0);
    check("basic_valid", {31'b0, o_valid}, 1);
    check("basic_sum", {16'b0, o_sum}, 32'h2345);
    check("basic_cout", {31'b0, o_cout}, 0);
    check("basic_ovf", {31'b0, o_ovf}, 0);

    send(16'hFFFF, 16'h0001, 1'b0);
    check("wrap_sum", {16'b0, o_sum}, 0);
    check("wrap_cout", {31'b0, o_cout}, 1);
    send(16'hFFFF, 16'h0000, 1'b1);
    check("cin_sum", {16'b0, o_sum}, 0);
    check("cin_cout", {31'b0, o_cout}, 1);
    check("cin_p_all", {31'b0, o_p_all}, 1);

    send(16'h7FFF, 16'h0001, 1'b0);
    check("pos_ovf", {31'b0, o_ovf}, 1);
    check("pos_sum", {16'b0, o_sum}, {16'b0, EXP_POS});
    send(16'h8000, 16'h8000, 1'b0);
    check("neg_ovf", {31'b0, o_ovf}, 1);
    check("neg_cout", {31'b0, o_cout}, 1);
    check("neg_sum", {16'b0, o_sum}, {16'b0, EXP_NEG});
    idle(2);

    // Backpressure: A in OUT, B in SKD, C held upstream.
    i_ready = 1'b0;
    send(16'h0101, 16'h0001, 1'b0);
    send(16'h0202, 16'h0002, 1'b0);
    drive(16'h0303, 16'h0003, 1'b0);
    repeat (3) step();
    check("stall_ready", {31'b0, o_ready}, 0);
    check("stall_out_a", {16'b0, o_sum}, 32'h0102);
    check("stall_valid", {31'b0, o_valid}, 1);
    i_ready = 1'b1;
    step();
    check("release_out_b", {16'b0, o_sum}, 32'h0204);
    check("release_ready", {31'b0, o_ready}, 1);
    wait_accept();
    i_valid = 1'b0;
    check("release_out_c", {16'b0, o_sum}, 32'h0306);
    idle(3);

    // Counter saturation, then clear coinciding with an overflowed accept.
    i_ovf_clr = 1'b1;
    step();
    i_ovf_clr = 1'b0;
    check("clr_cnt", {24'b0, o_ovf_cnt}, 0);
    check("clr_sticky", {31'b0, o_ovf_sticky}, 0);
    for (int i = 0; i < 300; i++) send(16'h7FFF, 16'h0001, 1'b0);
    idle(2);
    check("sat_cnt", {24'b0, o_ovf_cnt}, 255);
    check("sat_sticky", {31'b0, o_ovf_sticky}, 1);
    drive(16'h8000, 16'h8000, 1'b0);
    i_ovf_clr = 1'b1;
    wait_accept();
    i_ovf_clr = 1'b0;
    i_valid   = 1'b0;
    check("clr_acc_cnt", {24'b0, o_ovf_cnt}, 1);
    check("clr_acc_sticky", {31'b0, o_ovf_sticky}, 1);
    idle(2);

    rand_mode = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        send(16'($urandom), 16'($urandom), 1'($urandom));
      end else begin
        idle(1);
      end
    end
    rand_mode = 1'b0;
    i_ready   = 1'b1;
    i_ovf_clr = 1'b0;
    idle(4);
    check("drain_empty", q.size(), 0);

    // Asynchronous reset with OUT and SKD both full.
    i_ready = 1'b0;
    send(16'h7FFF, 16'h0001, 1'b0);
    send(16'h8000, 16'h8000, 1'b0);
    drive(16'h1111, 16'h1111, 1'b0);
    step();
    #2;
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    #1;
    check("arst_valid", {31'b0, o_valid}, 0);
    check("arst_ready", {31'b0, o_ready}, 1);
    check("arst_sum", {16'b0, o_sum}, 0);
    check("arst_flags", {28'b0, o_cout, o_ovf, o_p_all, o_ovf_sticky}, 0);
    check("arst_cnt", {24'b0, o_ovf_cnt}, 0);
    @(negedge i_clk);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    step();
    send(16'h0042, 16'h0001, 1'b0);
    check("post_rst_valid", {31'b0, o_valid}, 1);
    check("post_rst_sum", {16'b0, o_sum}, 32'h0043);
    idle(3);
    check("final_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
